// File: rtl/amm_sram_pkg.sv
// Shared definitions for the Avalon-MM to SRAM bridge blocks.
//   state_t : read-side FSM state encoding (IDLE, ISSUE, DRAIN, ACK)
//   TAG_W   : width of the lane-group tag carried alongside each SRAM read
//   beats() : number of SRAM beats needed to cover one 32-bit word
package amm_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  localparam int TAG_W = 2;

  function automatic int beats(input int dbytes);
    return 4 / dbytes;
  endfunction

endpackage

// File: rtl/amm_if.sv
// Avalon-MM slave-side bus bundle (32-bit data, byte addressed).
//   address, read, write, byteenable, writedata : master -> slave
//   readdata, waitrequest                       : slave -> master
// Handshake: a command is held by the master while waitrequest=1; the
// cycle with waitrequest=0 completes it and returns readdata.
interface amm_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest
  );

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );
endinterface

// File: rtl/sram_rd_pipe.sv
// Valid + lane-tag delay line matching the SRAM read latency.
//   clk      : clock
//   flush    : synchronous clear of every stage
//   in_valid : a read is issued this cycle
//   in_tag   : lane group of that read
//   out_valid/out_tag : the same pair P_DEPTH cycles later, aligned with
//                       the SRAM data for that read
module sram_rd_pipe #(
  parameter int P_DEPTH = 1,
  parameter int P_TW    = 2
) (
  input  logic            clk,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [P_TW-1:0] in_tag,
  output logic            out_valid,
  output logic [P_TW-1:0] out_tag
);

  logic            v_q [P_DEPTH];
  logic [P_TW-1:0] t_q [P_DEPTH];

  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < P_DEPTH; i++) begin
        v_q[i] <= 1'b0;
        t_q[i] <= '0;
      end
    end else begin
      v_q[0] <= in_valid;
      t_q[0] <= in_tag;
      for (int i = 1; i < P_DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        t_q[i] <= t_q[i-1];
      end
    end
  end

  assign out_valid = v_q[P_DEPTH-1];
  assign out_tag   = t_q[P_DEPTH-1];

endmodule

// File: rtl/amm2sram_rd.sv
// Avalon-MM read slave in front of a narrow single-port SRAM.
// Each 32-bit read is split into 4/P_DBYTES SRAM reads whose results are
// assembled into readdata; writes are acknowledged and dropped.
//   clk, reset  : clock, synchronous active-high reset
//   amm         : Avalon-MM slave port (waitrequest low for one cycle = done)
//   sram_raddr  : SRAM read address (holds last value when idle)
//   sram_re     : SRAM read enable, one cycle per beat
//   sram_rdata  : SRAM read data, valid P_RLAT cycles after sram_re
//   dbg_state   : current FSM state
module amm2sram_rd
  import amm_sram_pkg::*;
#(
  parameter int P_ASIZE  = 10,
  parameter int P_DBYTES = 4,
  parameter int P_RLAT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  amm_if.slave                  amm,
  output logic [P_ASIZE-1:0]    sram_raddr,
  output logic                  sram_re,
  input  logic [P_DBYTES*8-1:0] sram_rdata,
  output state_t                dbg_state
);

  if (!(P_DBYTES == 1 || P_DBYTES == 2 || P_DBYTES == 4)) begin : g_bad_dbytes
    $error("amm2sram_rd: P_DBYTES must be 1, 2 or 4");
  end
  if (!(P_RLAT == 1 || P_RLAT == 2)) begin : g_bad_rlat
    $error("amm2sram_rd: P_RLAT must be 1 or 2");
  end

  localparam int              N    = beats(P_DBYTES);
  localparam logic [TAG_W-1:0] LAST = TAG_W'(N - 1);

  // SRAM address of beat 0; later beats OR the beat index into the low
  // bits, which is the same mapping the write-side block uses.
  function automatic logic [P_ASIZE-1:0] base_addr(input logic [31:0] a);
    logic [P_ASIZE-1:0] r;
    r = a[P_ASIZE+1:2];
    if (P_DBYTES == 2) r = {a[P_ASIZE:2], 1'b0};
    else if (P_DBYTES == 1) r = {a[P_ASIZE-1:2], 2'b00};
    return r;
  endfunction

  state_t             state_q;
  logic [TAG_W-1:0]   beat_q;
  logic [P_ASIZE-1:0] base_q;
  logic [3:0]         be_q;
  logic [31:0]        readdata_q;
  logic               pipe_valid;
  logic [TAG_W-1:0]   pipe_tag;
  logic [TAG_W-1:0]   beat_nxt;

  assign beat_nxt = beat_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      be_q       <= '0;
      sram_re    <= 1'b0;
      sram_raddr <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (amm.read) begin
            base_q     <= base_addr(amm.address);
            be_q       <= amm.byteenable;
            beat_q     <= '0;
            sram_raddr <= base_addr(amm.address);
            sram_re    <= 1'b1;
            state_q    <= ST_ISSUE;
          end else if (amm.write) begin
            state_q <= ST_ACK;
          end
        end
        ST_ISSUE: begin
          if (beat_q == LAST) begin
            sram_re <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            beat_q     <= beat_nxt;
            sram_raddr <= base_q | {{(P_ASIZE-TAG_W){1'b0}}, beat_nxt};
          end
        end
        ST_DRAIN: begin
          if (pipe_valid && pipe_tag == LAST) state_q <= ST_ACK;
        end
        default: begin
          // ACK lasts one cycle; the bus is not looked at here, so a
          // command still held by the master cannot re-trigger.
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Tag travels with the read so the returning data lands in its lanes.
  sram_rd_pipe #(
    .P_DEPTH (P_RLAT),
    .P_TW    (TAG_W)
  ) u_pipe (
    .clk       (clk),
    .flush     (reset),
    .in_valid  (sram_re),
    .in_tag    (beat_q),
    .out_valid (pipe_valid),
    .out_tag   (pipe_tag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= '0;
    end else if (pipe_valid) begin
      for (int b = 0; b < 4; b++) begin
        if ((b / P_DBYTES) == int'(pipe_tag)) begin
          readdata_q[b*8 +: 8] <= be_q[b] ? sram_rdata[(b % P_DBYTES)*8 +: 8] : 8'h00;
        end
      end
    end
  end

  assign amm.readdata    = readdata_q;
  assign amm.waitrequest = (state_q != ST_ACK);
  assign dbg_state       = state_q;

  // Write data and the untranslated address bits have no use on a read port.
  logic unused_amm;
  assign unused_amm = ^{amm.writedata, amm.address};

endmodule

// File: tb/tb_amm2sram_rd.sv
// Directed bench for amm2sram_rd. Three instances share one command bus:
//   sel 0 : P_DBYTES=4, P_RLAT=1
//   sel 1 : P_DBYTES=1, P_RLAT=2
//   sel 2 : P_DBYTES=2, P_RLAT=1
// Each instance has its own behavioural SRAM; sel routes the command and
// picks which instance's outputs are observed.
module tb_amm2sram_rd;
  import amm_sram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- command bus ----------------
  logic [1:0]  sel = 2'd0;
  logic [31:0] cmd_addr = '0;
  logic        cmd_read = 1'b0;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_be = '0;
  logic [31:0] cmd_wdata = '0;

  amm_if bus4 ();
  amm_if bus1 ();
  amm_if bus2 ();

  assign bus4.address = cmd_addr;  assign bus4.byteenable = cmd_be;  assign bus4.writedata = cmd_wdata;
  assign bus1.address = cmd_addr;  assign bus1.byteenable = cmd_be;  assign bus1.writedata = cmd_wdata;
  assign bus2.address = cmd_addr;  assign bus2.byteenable = cmd_be;  assign bus2.writedata = cmd_wdata;
  assign bus4.read  = cmd_read  && (sel == 2'd0);
  assign bus4.write = cmd_write && (sel == 2'd0);
  assign bus1.read  = cmd_read  && (sel == 2'd1);
  assign bus1.write = cmd_write && (sel == 2'd1);
  assign bus2.read  = cmd_read  && (sel == 2'd2);
  assign bus2.write = cmd_write && (sel == 2'd2);

  // ---------------- DUTs + SRAM models ----------------
  logic [9:0]  raddr4, raddr1, raddr2;
  logic        re4, re1, re2;
  logic [31:0] rdata4;
  logic [7:0]  rdata1, s1a;
  logic [15:0] rdata2;
  state_t      st4, st1, st2;

  logic [31:0] mem4 [1024];
  logic [7:0]  mem1 [1024];
  logic [15:0] mem2 [1024];

  always @(posedge clk) if (re4) rdata4 <= mem4[raddr4];
  always @(posedge clk) begin
    if (re1) s1a <= mem1[raddr1];
    rdata1 <= s1a;
  end
  always @(posedge clk) if (re2) rdata2 <= mem2[raddr2];

  amm2sram_rd #(.P_ASIZE(10), .P_DBYTES(4), .P_RLAT(1)) u_dut4 (
    .clk(clk), .reset(reset), .amm(bus4), .sram_raddr(raddr4),
    .sram_re(re4), .sram_rdata(rdata4), .dbg_state(st4));
  amm2sram_rd #(.P_ASIZE(10), .P_DBYTES(1), .P_RLAT(2)) u_dut1 (
    .clk(clk), .reset(reset), .amm(bus1), .sram_raddr(raddr1),
    .sram_re(re1), .sram_rdata(rdata1), .dbg_state(st1));
  amm2sram_rd #(.P_ASIZE(10), .P_DBYTES(2), .P_RLAT(1)) u_dut2 (
    .clk(clk), .reset(reset), .amm(bus2), .sram_raddr(raddr2),
    .sram_re(re2), .sram_rdata(rdata2), .dbg_state(st2));

  // observed outputs of the selected instance
  logic        m_wait, m_re;
  logic [9:0]  m_raddr;
  logic [31:0] m_rdata;
  state_t      m_st;
  always_comb begin
    m_wait = bus4.waitrequest; m_re = re4; m_raddr = raddr4; m_rdata = bus4.readdata; m_st = st4;
    case (sel)
      2'd1: begin m_wait = bus1.waitrequest; m_re = re1; m_raddr = raddr1; m_rdata = bus1.readdata; m_st = st1; end
      2'd2: begin m_wait = bus2.waitrequest; m_re = re2; m_raddr = raddr2; m_rdata = bus2.readdata; m_st = st2; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q [$];
  logic [9:0]  re_addr_q [$];
  int          re_cyc_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one command on instance s, waits for the ACK, then drops it.
  // lat is the ACK cycle relative to the sampling cycle T (-1 on timeout).
  task automatic run_cmd(input logic [1:0] s, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output int lat, output logic [31:0] rdata);
    int stray;
    re_addr_q.delete();
    re_cyc_q.delete();
    lat = -1;
    rdata = '0;
    @(posedge clk); #1;
    sel = s; cmd_addr = addr; cmd_wdata = wdata; cmd_be = be;
    cmd_read = rd; cmd_write = wr;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (m_re) begin
        re_addr_q.push_back(m_raddr);
        re_cyc_q.push_back(c);
      end
      if (!m_wait) begin
        lat = c;
        rdata = m_rdata;
        break;
      end
    end
    if (lat < 0) check("ack_timeout", 32'hFFFF_FFFF, 32'd0);
    @(posedge clk); #1;
    cmd_read = 1'b0; cmd_write = 1'b0;
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (m_re || !m_wait) stray++;
    end
    check("after_ack_quiet", 32'(stray), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int          lat;
  logic [31:0] rd;
  logic [11:0] ack_mask, re_mask;
  int          cnt;

  initial begin
    mem4[5] = 32'hDEADBEEF;
    mem1[8] = 8'h11; mem1[9] = 8'h22; mem1[10] = 8'h33; mem1[11] = 8'h44;
    // writer mapping for P_DBYTES=2: word 12 -> SRAM 24 (low half), 25 (high half)
    mem2[24] = 16'hF00D; mem2[25] = 16'hCAFE;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    // reset state of every instance
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check("rst_wait", 32'(m_wait), 32'd1);
      check("rst_re", 32'(m_re), 32'd0);
      check("rst_raddr", 32'(m_raddr), 32'd0);
      check("rst_rdata", m_rdata, 32'd0);
      check("rst_state", 32'(m_st), 32'(ST_IDLE));
    end

    // 32-bit SRAM, latency 1
    exp_q.push_back(32'hDEADBEEF);
    run_cmd(2'd0, 1'b1, 1'b0, 32'h14, 32'h0, 4'hF, lat, rd);
    check("d4_lat", 32'(lat), 32'd3);
    check("d4_data", rd, exp_q.pop_front());
    check("d4_nre", 32'(re_addr_q.size()), 32'd1);
    if (re_addr_q.size() == 1) begin
      check("d4_raddr", 32'(re_addr_q[0]), 32'd5);
      check("d4_recyc", 32'(re_cyc_q[0]), 32'd1);
    end

    // address bits [1:0] ignored
    run_cmd(2'd0, 1'b1, 1'b0, 32'h17, 32'h0, 4'hF, lat, rd);
    check("d4_lowbits", rd, 32'hDEADBEEF);

    // all lanes disabled: read still issued, data zeroed
    run_cmd(2'd0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0, lat, rd);
    check("d4_be0_data", rd, 32'h0);
    check("d4_be0_nre", 32'(re_addr_q.size()), 32'd1);

    // 8-bit SRAM, latency 2
    exp_q.push_back(32'h44332211);
    run_cmd(2'd1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, lat, rd);
    check("d1_lat", 32'(lat), 32'd7);
    check("d1_data", rd, exp_q.pop_front());
    check("d1_nre", 32'(re_addr_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < re_addr_q.size()) begin
        check("d1_raddr", 32'(re_addr_q[i]), 32'(8 + i));
        check("d1_recyc", 32'(re_cyc_q[i]), 32'(1 + i));
      end
    end
    run_cmd(2'd1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h5, lat, rd);
    check("d1_be5", rd, 32'h00330011);

    // 16-bit SRAM, data laid down by the writer
    run_cmd(2'd2, 1'b1, 1'b0, 32'h30, 32'h0, 4'h3, lat, rd);
    check("d2_be3", rd, 32'h0000F00D);
    check("d2_nre", 32'(re_addr_q.size()), 32'd2);
    check("d2_lat", 32'(lat), 32'd4);
    if (re_addr_q.size() == 2) begin
      check("d2_raddr0", 32'(re_addr_q[0]), 32'd24);
      check("d2_raddr1", 32'(re_addr_q[1]), 32'd25);
    end
    run_cmd(2'd2, 1'b1, 1'b0, 32'h30, 32'h0, 4'hC, lat, rd);
    check("d2_beC", rd, 32'hCAFE0000);
    run_cmd(2'd2, 1'b1, 1'b0, 32'h30, 32'h0, 4'hA, lat, rd);
    check("d2_beA", rd, 32'hCA00F000);

    // write-only commands: ACK next cycle, nothing reaches the SRAM
    run_cmd(2'd0, 1'b0, 1'b1, 32'h14, 32'h12345678, 4'hF, lat, rd);
    check("wr4_lat", 32'(lat), 32'd1);
    check("wr4_nre", 32'(re_addr_q.size()), 32'd0);
    run_cmd(2'd1, 1'b0, 1'b1, 32'h8, 32'h12345678, 4'hF, lat, rd);
    check("wr1_lat", 32'(lat), 32'd1);
    check("wr1_nre", 32'(re_addr_q.size()), 32'd0);

    // read wins over write
    run_cmd(2'd0, 1'b1, 1'b1, 32'h14, 32'h12345678, 4'hF, lat, rd);
    check("rdwr_lat", 32'(lat), 32'd3);
    check("rdwr_data", rd, 32'hDEADBEEF);

    // read held on the bus: one transaction every 4 cycles on instance 0
    @(posedge clk); #1;
    sel = 2'd0; cmd_addr = 32'h14; cmd_be = 4'hF; cmd_read = 1'b1;
    ack_mask = '0; re_mask = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!m_wait) ack_mask[c] = 1'b1;
      if (m_re) re_mask[c] = 1'b1;
    end
    @(posedge clk); #1 cmd_read = 1'b0;
    check("b2b_ack", 32'(ack_mask), 32'h888);
    check("b2b_re", 32'(re_mask), 32'h222);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_re || !m_wait) cnt++;
    end
    check("b2b_tail", 32'(cnt), 32'd0);

    // reset in the middle of the 8-bit burst
    @(posedge clk); #1;
    sel = 2'd1; cmd_addr = 32'h8; cmd_be = 4'hF; cmd_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_in_issue", 32'(m_st), 32'(ST_ISSUE));
    @(posedge clk); #1;
    reset = 1'b1; cmd_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_re", 32'(m_re), 32'd0);
    check("mid_wait", 32'(m_wait), 32'd1);
    check("mid_rdata", m_rdata, 32'd0);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_re || !m_wait) cnt++;
    end
    check("mid_no_ack", 32'(cnt), 32'd0);
    run_cmd(2'd1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, lat, rd);
    check("mid_reread", rd, 32'h44332211);
    check("mid_relat", 32'(lat), 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
